// File: rtl/srv1_lsu_pkg.sv
// Shared types and constants for the SRV1 load/store bus master.
package srv1_lsu_pkg;

    // Width of the ack timeout counter
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ALIGN   = 2'd1,
        FC_BUS     = 2'd2,
        FC_TIMEOUT = 2'd3
    } fault_cause_e;

    // RV32I funct3 encodings for loads and stores
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    // Access size, taken from funct3[1:0]
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Registered bus command, held stable for the whole transaction
    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_cmd_t;

    // Stores have no unsigned variants; loads have no unsigned word
    function automatic logic fn3_legal(input logic is_store, input logic [2:0] fn3);
        if (is_store)
            return fn3 inside {SB, SH, SW};
        return fn3 inside {LB, LH, LW, LBU, LHU};
    endfunction

endpackage

// File: rtl/output_adj.sv
// Store data aligner and byte-enable generator; mirror of the load-side adjuster.
module output_adj
    import srv1_lsu_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [2:0]  fn3,
    input  logic [1:0]  addr_low,
    output logic [31:0] data_out,
    output logic [3:0]  be,
    output logic        misaligned
);

    // Signedness bit has no meaning on the store side
    logic unused_fn3_hi;
    assign unused_fn3_hi = fn3[2];

    // Replicate the operand across lanes and pick lanes from the address
    always_comb begin
        data_out   = data_in;
        be         = 4'b1111;
        misaligned = 1'b0;
        case (fn3[1:0])
            SZ_B: begin
                data_out = {4{data_in[7:0]}};
                be       = 4'b0001 << addr_low;
            end
            SZ_H: begin
                data_out   = {2{data_in[15:0]}};
                be         = addr_low[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_low[0];
            end
            SZ_W: begin
                misaligned = |addr_low;
            end
            default: begin
                // size 3 does not exist in RV32I
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus master: validates the op, runs one req/ack transaction,
// stalls the pipeline meanwhile and strobes the result to writeback.
module lsu_bus_master
    import srv1_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  fn3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data_out,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state;
    bus_cmd_t         cmd_q;
    logic             discard;
    logic [CNT_W-1:0] tmo_cnt;

    logic [31:0] adj_data;
    logic [3:0]  adj_be;
    logic        adj_mis;
    logic        op_bad;
    logic        accept;
    logic        killed;

    output_adj u_adj (
        .data_in    (store_data_in),
        .fn3        (fn3_in),
        .addr_low   (addr_in[1:0]),
        .data_out   (adj_data),
        .be         (adj_be),
        .misaligned (adj_mis)
    );

    assign op_bad = adj_mis | ~fn3_legal(req_store, fn3_in);
    assign accept = (state == IDLE) & req_valid & ~flush;
    // A flush arriving in the completing cycle still suppresses the result
    assign killed = discard | flush;

    assign bus_we    = cmd_q.we;
    assign bus_addr  = cmd_q.addr;
    assign bus_be    = cmd_q.be;
    assign bus_wdata = cmd_q.wdata;

    // Stall must answer req_valid/flush in the same cycle, so it is combinational
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = req_valid & ~flush;
            // While discarding, only a newly arriving op is held off
            BUSY:    stall = killed ? (req_valid & ~flush) : 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Transaction FSM with registered bus and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cmd_q         <= '0;
            discard       <= 1'b0;
            tmo_cnt       <= '0;
            done          <= 1'b0;
            fault         <= 1'b0;
            fault_cause   <= FC_NONE;
            bus_req       <= 1'b0;
            load_data_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op_bad) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= FC_ALIGN;
                        end else begin
                            state       <= BUSY;
                            bus_req     <= 1'b1;
                            cmd_q.we    <= req_store;
                            cmd_q.addr  <= addr_in[31:2];
                            cmd_q.be    <= adj_be;
                            cmd_q.wdata <= req_store ? adj_data : 32'd0;
                            tmo_cnt     <= '0;
                            discard     <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (flush)
                        discard <= 1'b1;
                    // ack takes priority over a timeout expiring in the same cycle
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        discard <= 1'b0;
                        if (killed) begin
                            state <= IDLE;
                        end else begin
                            state       <= DONE;
                            done        <= 1'b1;
                            fault       <= bus_err;
                            fault_cause <= bus_err ? FC_BUS : FC_NONE;
                            if (!cmd_q.we)
                                load_data_out <= bus_rdata;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus_req <= 1'b0;
                        discard <= 1'b0;
                        if (killed) begin
                            state <= IDLE;
                        end else begin
                            state       <= DONE;
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= FC_TIMEOUT;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    fault       <= 1'b0;
                    fault_cause <= FC_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized scoreboard bench for lsu_bus_master with a reactive bus slave.
module tb_lsu_bus_master;

    localparam int T = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  fn3_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] load_data_out;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    lsu_bus_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_store     (req_store),
        .fn3_in        (fn3_in),
        .addr_in       (addr_in),
        .store_data_in (store_data_in),
        .flush         (flush),
        .stall         (stall),
        .done          (done),
        .load_data_out (load_data_out),
        .fault         (fault),
        .fault_cause   (fault_cause),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_err       (bus_err),
        .bus_rdata     (bus_rdata)
    );

    typedef struct {
        bit        we;
        bit [29:0] addr;
        bit [3:0]  be;
        bit [31:0] wdata;
        int        wt;
        bit        err;
        bit [31:0] rdata;
    } btx_t;

    typedef struct {
        bit        fault;
        bit [1:0]  cause;
        bit        chk_data;
        bit [31:0] data;
    } resp_t;

    btx_t      bus_q[$];
    resp_t     resp_q[$];
    int        n_checks = 0;
    int        n_err    = 0;
    bit [31:0] last_ld  = 0;
    bit        stray_ack = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: an access of n bytes covers lanes [lo, lo+n); store bytes repeat every n lanes
    function automatic void model(input bit st, input bit [2:0] f, input bit [31:0] a,
                                  input bit [31:0] d, output bit legal,
                                  output bit [3:0] be, output bit [31:0] wd);
        int n, lo;
        bit ok_fn;
        ok_fn = st ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n     = 1 << f[1:0];
        lo    = int'(a[1:0]);
        legal = ok_fn && (lo % n == 0);
        be    = '0;
        wd    = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= lo && i < lo + n) be[i] = 1'b1;
            if (st) wd[8*i +: 8] = d[8*(i % n) +: 8];
        end
    endfunction

    // Queue expectations for one op; returns cycles from acceptance to done
    task automatic prep(input bit st, input bit [2:0] f, input bit [31:0] a, input bit [31:0] d,
                        input int wt, input bit er, input bit [31:0] rd, input bit killed,
                        output int exp_lat, output bit legal);
        bit [3:0]  be;
        bit [31:0] wd;
        btx_t      bt;
        resp_t     rs;
        model(st, f, a, d, legal, be, wd);
        rs = '{fault: 1'b1, cause: 2'd1, chk_data: 1'b0, data: 32'd0};
        exp_lat = 1;
        if (legal) begin
            bt = '{we: st, addr: a[31:2], be: be, wdata: wd, wt: wt, err: er, rdata: rd};
            bus_q.push_back(bt);
            if (wt < T) begin
                rs = '{fault: er, cause: er ? 2'd2 : 2'd0, chk_data: !st && !er, data: rd};
                exp_lat = wt + 2;
                if (!st && !killed) last_ld = rd;
            end else begin
                rs.cause = 2'd3;
                exp_lat  = T + 1;
            end
        end
        if (!killed) resp_q.push_back(rs);
    endtask

    task automatic drive(input bit st, input bit [2:0] f, input bit [31:0] a, input bit [31:0] d);
        req_valid = 1; req_store = st; fn3_in = f; addr_in = a; store_data_in = d;
    endtask

    task automatic run_op(input bit st, input bit [2:0] f, input bit [31:0] a, input bit [31:0] d,
                          input int wt, input bit er, input bit [31:0] rd);
        int exp_lat, lat, bad;
        bit legal;
        prep(st, f, a, d, wt, er, rd, 1'b0, exp_lat, legal);
        @(negedge clk);
        drive(st, f, a, d);
        #1 chk("stall_accept", stall, 1);
        lat = 0; bad = 0;
        do begin
            @(negedge clk); #1;
            lat++;
            if (lat == 1) chk("bus_req_start", bus_req, legal);
            if (!done && !stall) bad++;
        end while (!done && lat < 40);
        chk("done_latency", lat, exp_lat);
        chk("stall_held", bad, 0);
        chk("stall_in_done", stall, 0);
    endtask

    // Flush the first op in its 2nd BUSY cycle, then offer a second op while discarding
    task automatic run_flush(input int w1, input int w2);
        int exp_lat, lat, w1e;
        bit legal;
        bit [31:0] a2, d2;
        prep(1'b0, 3'd2, 32'h0000_3000, 32'd0, w1, 1'b0, $urandom, 1'b1, exp_lat, legal);
        @(negedge clk);
        drive(1'b0, 3'd2, 32'h0000_3000, 32'd0);
        #1 chk("fl_stall_accept", stall, 1);
        @(negedge clk); #1 chk("fl_busy0", bus_req, 1);
        @(negedge clk);
        flush = 1; req_valid = 0;
        #1 chk("flush_stall", stall, 0);
        @(negedge clk);
        flush = 0;
        a2 = $urandom; d2 = $urandom;
        prep(1'b1, 3'd0, a2, d2, w2, 1'b0, 32'd0, 1'b0, exp_lat, legal);
        drive(1'b1, 3'd0, a2, d2);
        #1;
        chk("discard_hold", stall, 1);
        chk("discard_busy", bus_req, 1);
        lat = 0;
        do begin
            @(negedge clk); #1;
            lat++;
        end while (!done && lat < 40);
        w1e = (w1 < T) ? w1 : T - 1;
        chk("discard_then_op", lat, w1e + w2 + 1);
        chk("discard_ld_kept", load_data_out, last_ld);
    endtask

    // Reactive slave: checks the command on every request cycle, acks after wt waits
    initial begin
        btx_t cur;
        bit   in_txn;
        int   cnt;
        in_txn = 0; cnt = 0;
        cur = '{we: 0, addr: 0, be: 0, wdata: 0, wt: -1, err: 0, rdata: 0};
        bus_ack = 0; bus_err = 0; bus_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst_n && bus_req) begin
                if (!in_txn) begin
                    in_txn = 1; cnt = 0;
                    if (bus_q.size() == 0) chk("bus_unexpected", bus_req, 0);
                    else cur = bus_q.pop_front();
                end
                chk("bus_we", bus_we, cur.we);
                chk("bus_addr", bus_addr, cur.addr);
                chk("bus_be", bus_be, cur.be);
                chk("bus_wdata", bus_wdata, cur.wdata);
                if (cnt == cur.wt) begin
                    bus_ack = 1; bus_err = cur.err; bus_rdata = cur.rdata;
                end else begin
                    bus_ack = 0; bus_err = 0; bus_rdata = $urandom;
                end
                cnt++;
            end else begin
                in_txn    = 0;
                bus_ack   = stray_ack;
                bus_err   = 0;
                bus_rdata = stray_ack ? 32'hDEAD_BEEF : 32'd0;
            end
        end
    end

    // Monitor: every done pulse consumes one expected result
    initial begin
        resp_t e;
        forever begin
            @(negedge clk); #1;
            if (rst_n && done) begin
                if (resp_q.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    e = resp_q.pop_front();
                    chk("fault", fault, e.fault);
                    chk("fault_cause", fault_cause, e.cause);
                    if (e.chk_data) chk("load_data", load_data_out, e.data);
                end
            end else if (rst_n && fault) begin
                chk("fault_without_done", fault, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; req_valid = 0; req_store = 0; fn3_in = 0; addr_in = 0;
        store_data_in = 0; flush = 0;
        #12;
        chk("rst_ctl", {stall, done, fault, fault_cause, bus_req, bus_we}, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_ldata", load_data_out, 0);
        @(negedge clk); rst_n = 1;

        // directed cases
        run_op(1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 32'd0);
        run_op(0, 3'd2, 32'h0000_2000, 32'd0, 3, 0, 32'h1234_5678);
        run_op(0, 3'd1, 32'h0000_0001, 32'd0, 0, 0, 32'd0);
        run_op(0, 3'd3, 32'h0000_0000, 32'd0, 0, 0, 32'd0);
        run_op(1, 3'd2, 32'h0000_0010, 32'hCAFE_F00D, 1, 1, 32'd0);
        chk("bus_req_after_err", bus_req, 0);
        run_op(1, 3'd1, 32'h0000_0006, 32'h1111_BEEF, 0, 0, 32'd0);
        run_op(0, 3'd5, 32'h0000_0042, 32'd0, 2, 0, 32'h8765_4321);
        run_op(0, 3'd4, 32'h0000_0043, 32'd0, 0, 0, 32'h0000_00F1);
        run_op(1, 3'd4, 32'h0000_0040, 32'd0, 0, 0, 32'd0);
        run_op(1, 3'd2, 32'h0000_0052, 32'd0, 0, 0, 32'd0);
        run_op(0, 3'd2, 32'h0000_0060, 32'd0, T - 1, 0, 32'h5A5A_A5A5);

        // timeout, then a stray ack while idle
        run_op(0, 3'd2, 32'h0000_0070, 32'd0, 99, 0, 32'd0);
        @(negedge clk); req_valid = 0;
        @(posedge clk); stray_ack = 1;
        @(posedge clk); stray_ack = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("stray_ack_ldata", load_data_out, last_ld);
        chk("stray_ack_bus_req", bus_req, 0);

        // flush while idle: nothing accepted
        @(negedge clk);
        drive(0, 3'd2, 32'h0000_0080, 32'd0);
        flush = 1;
        #1 chk("flush_idle_stall", stall, 0);
        @(negedge clk);
        req_valid = 0; flush = 0;
        #1 chk("flush_idle_no_req", bus_req, 0);

        run_flush(3, 0);
        run_flush(99, 1);

        // async reset in the middle of a transaction
        begin
            int  el;
            bit  lg;
            prep(0, 3'd2, 32'h0000_0090, 32'd0, 99, 0, 32'd0, 1'b1, el, lg);
            @(negedge clk);
            drive(0, 3'd2, 32'h0000_0090, 32'd0);
            @(negedge clk);
            @(negedge clk);
            req_valid = 0;
            #2 rst_n = 0;
            #1;
            chk("mid_rst_ctl", {stall, done, fault, fault_cause, bus_req, bus_we}, 0);
            chk("mid_rst_addr", bus_addr, 0);
            chk("mid_rst_be", bus_be, 0);
            chk("mid_rst_ldata", load_data_out, 0);
            last_ld = 0;
            @(negedge clk); rst_n = 1;
        end

        // randomized back-to-back ops
        for (int i = 0; i < 80; i++) begin
            bit        st;
            bit [2:0]  f;
            bit [31:0] a;
            st = 1'($urandom % 2);
            f  = 3'($urandom % 8);
            a  = $urandom;
            run_op(st, f, a, $urandom, $urandom_range(0, 5), ($urandom % 6) == 0, $urandom);
        end

        @(negedge clk); req_valid = 0;
        repeat (6) @(negedge clk);
        chk("resp_q_drained", resp_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
